// File: rtl/reg_file_2r1w.sv
// 32 x 64-bit register file, two combinational read ports, one write port.
// Ports:
//   Clk, Reset_n          clock and synchronous active-low reset
//   RA, RB / BusA, BusB   read addresses and read data (with same-cycle bypass)
//   RW, RegWr, BusW       write address, write enable, write data
//   WrCount               committed-write counter, wraps at 16 bits
module reg_file_2r1w #(
    parameter int n    = 64,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic [AW-1:0] RA,
    input  logic [AW-1:0] RB,
    input  logic [AW-1:0] RW,
    input  logic          RegWr,
    input  logic [n-1:0]  BusW,
    output logic [n-1:0]  BusA,
    output logic [n-1:0]  BusB,
    output logic [15:0]   WrCount
);

    // Top index is the hardwired zero register and has no storage.
    localparam logic [AW-1:0] ZeroIdx = AW'(NREG - 1);

    logic [n-1:0] regs [NREG-1];

    logic wrValid;

    assign wrValid = RegWr && (RW != ZeroIdx);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < NREG - 1; i++) begin
                regs[i] <= '0;
            end
            WrCount <= '0;
        end else if (wrValid) begin
            regs[RW] <= BusW;
            WrCount  <= WrCount + 16'd1;
        end
    end

    // Bypass ignores Reset_n so the read path depends only on inputs
    // and current state.
    always_comb begin
        BusA = '0;
        if (RA != ZeroIdx) begin
            if (RegWr && (RW == RA)) begin
                BusA = BusW;
            end else begin
                BusA = regs[RA];
            end
        end
    end

    always_comb begin
        BusB = '0;
        if (RB != ZeroIdx) begin
            if (RegWr && (RW == RB)) begin
                BusB = BusW;
            end else begin
                BusB = regs[RB];
            end
        end
    end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- 32-entry register file with two read ports and one write port, 64 bits per entry.
- Sits directly upstream of the ALU: its read ports drive the ALU's BusA/BusB operand buses.
- Its write port takes the writeback value on BusW, which comes from the ALU result or the memory-load mux.
- Register 31 is the architectural zero register (XZR). Same-cycle write-to-read bypass lets the single-cycle datapath see a value in the cycle it is written.

Parameters:
- n, 64, data width of every register and bus.
- NREG, 32, number of architectural registers; index NREG-1 is hardwired zero.
- AW, 5, register index width; must satisfy 2**AW == NREG.

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Reset_n  input  1  synchronous, active-low reset, sampled on rising edge of Clk.
- RA  input  AW  read address, port A.
- RB  input  AW  read address, port B.
- RW  input  AW  write address.
- RegWr  input  1  write enable.
- BusW  input  n  write data.
- BusA  output  n  read data, port A, to ALU BusA.
- BusB  output  n  read data, port B, to ALU BusB.
- WrCount  output  16  count of committed writes since reset; debug aid.

Behaviour:
- Storage: registers 0..NREG-2 are n-bit flops. Register NREG-1 has no storage and always reads zero.
- Reset:
  - Rising edge with Reset_n=0 clears all stored registers to 0 and WrCount to 0.
  - Reset has priority over a simultaneous write: the write is dropped and WrCount does not increment.
  - A write asserted in the cycle reset is released (Reset_n=1 at that edge) commits normally.
- Reset mid-operation: any value written before the reset edge is lost. The first cycle after the reset edge reads 0 from every register unless the bypass applies.
- Write:
  - At rising edge, if Reset_n=1, RegWr=1 and RW!=NREG-1, then reg[RW] <= BusW and WrCount increments by 1.
  - A write to RW==NREG-1 is silently discarded; WrCount does not increment.
  - RegWr=0 leaves all state unchanged.
- Read: combinational, zero-cycle latency; BusA is a function of RA and the current state.
- Bypass:
  - If RegWr=1, RW==RA and RA!=NREG-1, BusA = BusW in the same cycle, not the stored value. BusB behaves identically with RB.
  - Bypass is active regardless of Reset_n, so outputs stay a pure function of current inputs and state.
- Zero register: RA==NREG-1 gives BusA=0 at all times, including when RegWr=1 and RW==NREG-1 with nonzero BusW. The same holds for RB.
- Same address on both ports: RA==RB returns identical data on both buses, including the bypass case.
- WrCount wraps: 16'hFFFF plus one committed write gives 16'h0000, with no sticky flag.
- No X propagation: after reset, every output is a defined value for every defined input combination.
- Reset values:
  - BusA and BusB read 0 after reset for any RA/RB when RegWr=0.
  - WrCount = 0.

Test Plan:
- Reset_n=0 for 2 cycles, then release with RegWr=0; sweep RA/RB over 0..31 -> BusA=BusB=0 everywhere, WrCount=0.
- Write 64'hDEADBEEF_CAFEF00D to RW=5, then RegWr=0 and RA=5, RB=5 -> BusA=BusB=64'hDEADBEEF_CAFEF00D, WrCount=1.
- RegWr=1, RW=7, BusW=64'h1234, RA=7, before the edge -> BusA=64'h1234 combinationally (bypass). After the edge with RegWr=0 -> BusA=64'h1234 from storage.
- RegWr=1, RW=31, BusW=64'hFFFF_FFFF_FFFF_FFFF, RA=31 -> BusA=0 both before and after the edge; WrCount unchanged.
- Write x3=64'hA at one edge; next edge has Reset_n=0 and RegWr=1, RW=4, BusW=64'hB -> x3=x4=0 after the edge, WrCount=0.
- Preload WrCount to 16'hFFFE via 65534 writes, then 2 more writes to x1 -> WrCount=16'h0000, x1 holds the last value written.
